// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath.
// Sequences fetch/decode/execute/memory/write-back with memory-ready stalls.
module multicycle_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Op,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       AluSrcA,
  output logic [1:0] AluSrcB,
  output logic [1:0] AluOp,
  output logic [1:0] PCSource,
  output logic       IllegalOp,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    sRst    = 4'd0,
    sFetch  = 4'd1,
    sDecode = 4'd2,
    sMemAdr = 4'd3,
    sMemRd  = 4'd4,
    sMemWb  = 4'd5,
    sMemWr  = 4'd6,
    sExec   = 4'd7,
    sRwb    = 4'd8,
    sBranch = 4'd9,
    sJump   = 4'd10,
    sAddiEx = 4'd11,
    sAddiWb = 4'd12
  } state_t;

  typedef struct packed {
    logic       pcWrite;
    logic       pcWriteCond;
    logic       iorD;
    logic       memRead;
    logic       memWrite;
    logic       memtoReg;
    logic       regDst;
    logic       regWrite;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] aluOp;
    logic [1:0] pcSource;
  } ctrl_t;

  localparam logic [5:0] OpR    = 6'b000000;
  localparam logic [5:0] OpLw   = 6'b100011;
  localparam logic [5:0] OpSw   = 6'b101011;
  localparam logic [5:0] OpBeq  = 6'b000100;
  localparam logic [5:0] OpJ    = 6'b000010;
  localparam logic [5:0] OpAddi = 6'b001000;

  state_t state;
  state_t nxt;
  ctrl_t  ctrl;

  logic isR, isLw, isSw, isBeq, isJ, isAddi, legal;

  assign isR    = (Op == OpR);
  assign isLw   = (Op == OpLw);
  assign isSw   = (Op == OpSw);
  assign isBeq  = (Op == OpBeq);
  assign isJ    = (Op == OpJ);
  assign isAddi = (Op == OpAddi);
  assign legal  = isR | isLw | isSw | isBeq | isJ | isAddi;

  function automatic ctrl_t decode(state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      sFetch: begin
        c.memRead = 1'b1;
        c.aluSrcB = 2'b01;
      end
      sDecode: c.aluSrcB = 2'b11;
      sMemAdr, sAddiEx: begin
        c.aluSrcA = 1'b1;
        c.aluSrcB = 2'b10;
      end
      sMemRd: begin
        c.memRead = 1'b1;
        c.iorD    = 1'b1;
      end
      sMemWb: begin
        c.regWrite = 1'b1;
        c.memtoReg = 1'b1;
      end
      sMemWr: begin
        c.memWrite = 1'b1;
        c.iorD     = 1'b1;
      end
      sExec: begin
        c.aluSrcA = 1'b1;
        c.aluOp   = 2'b10;
      end
      sRwb: begin
        c.regWrite = 1'b1;
        c.regDst   = 1'b1;
      end
      sBranch: begin
        c.aluSrcA     = 1'b1;
        c.aluOp       = 2'b01;
        c.pcWriteCond = 1'b1;
        c.pcSource    = 2'b01;
      end
      sJump: begin
        c.pcWrite  = 1'b1;
        c.pcSource = 2'b10;
      end
      sAddiWb: c.regWrite = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    nxt = sFetch;
    case (state)
      sFetch:  nxt = MemReady ? sDecode : sFetch;
      sDecode: begin
        unique case (1'b1)
          isLw | isSw: nxt = sMemAdr;
          isR:         nxt = sExec;
          isBeq:       nxt = sBranch;
          isJ:         nxt = sJump;
          isAddi:      nxt = sAddiEx;
          default:     nxt = sFetch;
        endcase
      end
      sMemAdr: nxt = isLw ? sMemRd : sMemWr;
      sMemRd:  nxt = MemReady ? sMemWb : sMemRd;
      sMemWr:  nxt = MemReady ? sFetch : sMemWr;
      sExec:   nxt = sRwb;
      sAddiEx: nxt = sAddiWb;
      default: nxt = sFetch;
    endcase
  end

  // Moore outputs are registered from the next state so they line up with State.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= sRst;
      ctrl  <= '0;
    end else begin
      state <= nxt;
      ctrl  <= decode(nxt);
    end
  end

  assign State       = state;
  assign IRWrite     = (state == sFetch) & MemReady;
  assign PCWrite     = ctrl.pcWrite | IRWrite;
  assign IllegalOp   = (state == sDecode) & ~legal;
  assign PCWriteCond = ctrl.pcWriteCond;
  assign IorD        = ctrl.iorD;
  assign MemRead     = ctrl.memRead;
  assign MemWrite    = ctrl.memWrite;
  assign MemtoReg    = ctrl.memtoReg;
  assign RegDst      = ctrl.regDst;
  assign RegWrite    = ctrl.regWrite;
  assign AluSrcA     = ctrl.aluSrcA;
  assign AluSrcB     = ctrl.aluSrcB;
  assign AluOp       = ctrl.aluOp;
  assign PCSource    = ctrl.pcSource;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: vector table driven each cycle,
// expected state/controls queued at drive time and compared after settle.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] Op;
  logic       MemReady;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, AluSrcA, IllegalOp;
  logic [1:0] AluSrcB, AluOp, PCSource;
  logic [3:0] State;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk(clk), .reset(reset), .Op(Op), .MemReady(MemReady),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .AluSrcA(AluSrcA), .AluSrcB(AluSrcB), .AluOp(AluOp),
    .PCSource(PCSource), .IllegalOp(IllegalOp), .State(State)
  );

  typedef struct {
    logic       rst;
    logic [5:0] op;
    logic       mr;
    logic [3:0] st;
  } vec_t;

  typedef struct {
    logic [3:0]  st;
    logic [16:0] o;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  localparam logic [5:0] R    = 6'b000000;
  localparam logic [5:0] LW   = 6'b100011;
  localparam logic [5:0] SW   = 6'b101011;
  localparam logic [5:0] BEQ  = 6'b000100;
  localparam logic [5:0] JMP  = 6'b000010;
  localparam logic [5:0] ADDI = 6'b001000;
  localparam logic [5:0] BAD  = 6'b111111;

  // Reference control table written straight from the state descriptions.
  function automatic logic [16:0] expOut(logic [3:0] st, logic mrdy, logic [5:0] op);
    logic pw, pwc, iod, mrd, mw, irw, m2r, rd, rw, sa, ill;
    logic [1:0] sbv, ao, ps;
    {pw, pwc, iod, mrd, mw, irw, m2r, rd, rw, sa, ill} = '0;
    sbv = 2'b00; ao = 2'b00; ps = 2'b00;
    case (st)
      4'd1:  begin mrd = 1; sbv = 2'b01; irw = mrdy; pw = mrdy; end
      4'd2:  begin
        sbv = 2'b11;
        ill = !(op == R || op == LW || op == SW || op == BEQ || op == JMP || op == ADDI);
      end
      4'd3:  begin sa = 1; sbv = 2'b10; end
      4'd4:  begin mrd = 1; iod = 1; end
      4'd5:  begin rw = 1; m2r = 1; end
      4'd6:  begin mw = 1; iod = 1; end
      4'd7:  begin sa = 1; ao = 2'b10; end
      4'd8:  begin rw = 1; rd = 1; end
      4'd9:  begin sa = 1; ao = 2'b01; pwc = 1; ps = 2'b01; end
      4'd10: begin pw = 1; ps = 2'b10; end
      4'd11: begin sa = 1; sbv = 2'b10; end
      4'd12: rw = 1;
      default: ;
    endcase
    return {pw, pwc, iod, mrd, mw, irw, m2r, rd, rw, sa, sbv, ao, ps, ill};
  endfunction

  task automatic add(input logic r, input logic [5:0] o, input logic m, input logic [3:0] s);
    vec_t v;
    v.rst = r; v.op = o; v.mr = m; v.st = s;
    vecs.push_back(v);
  endtask

  initial begin
    logic [16:0] got;
    exp_t e;

    // reset release, fetch
    add(0, R, 1, 0);
    add(0, R, 1, 1);
    // lw, no stalls; Op garbage in MEMRD must be ignored
    add(0, LW, 1, 2);
    add(0, LW, 1, 3);
    add(0, BAD, 1, 4);
    add(0, R, 1, 5);
    add(0, R, 1, 1);
    // sw with 3-cycle stall in MEMWR
    add(0, SW, 1, 2);
    add(0, SW, 1, 3);
    add(0, SW, 0, 6);
    add(0, SW, 0, 6);
    add(0, SW, 0, 6);
    add(0, SW, 1, 6);
    // fetch stall 2 cycles, then R-type
    add(0, R, 0, 1);
    add(0, R, 0, 1);
    add(0, R, 1, 1);
    add(0, R, 1, 2);
    add(0, LW, 1, 7);
    add(0, SW, 1, 8);
    add(0, R, 1, 1);
    // beq
    add(0, BEQ, 1, 2);
    add(0, BEQ, 1, 9);
    add(0, R, 1, 1);
    // illegal
    add(0, BAD, 1, 2);
    add(0, R, 1, 1);
    // j
    add(0, JMP, 1, 2);
    add(0, JMP, 1, 10);
    add(0, R, 1, 1);
    // addi
    add(0, ADDI, 1, 2);
    add(0, ADDI, 1, 11);
    add(0, ADDI, 1, 12);
    // lw stalled in MEMRD, then reset mid-stall
    add(0, LW, 1, 1);
    add(0, LW, 1, 2);
    add(0, LW, 1, 3);
    add(0, LW, 0, 4);
    add(0, LW, 0, 4);
    add(1, LW, 0, 4);
    add(1, LW, 0, 0);
    add(0, LW, 1, 0);
    add(0, LW, 1, 1);

    reset = 1'b1; Op = R; MemReady = 1'b0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      reset = vecs[i].rst;
      Op = vecs[i].op;
      MemReady = vecs[i].mr;
      e.st = vecs[i].st;
      e.o = expOut(vecs[i].st, vecs[i].mr, vecs[i].op);
      sb.push_back(e);
      #1;
      got = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
             MemtoReg, RegDst, RegWrite, AluSrcA, AluSrcB, AluOp,
             PCSource, IllegalOp};
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL scoreboard_empty row=%0d", i);
      end else begin
        e = sb.pop_front();
        if (State !== e.st) begin
          failures++;
          $display("FAIL state row=%0d got=%0d want=%0d", i, State, e.st);
        end
        checks++;
        if (got !== e.o) begin
          failures++;
          $display("FAIL outputs row=%0d state=%0d got=%b want=%b", i, State, got, e.o);
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
